ps2_scan_decoder: RTL and testbench
===================================

PS2_SCAN_DECODER -- requirements
Module: ps2_scan_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event FIFO depth; power of two, 2..16.
REQ-002 SHALL have ports `clk_i` (in, 1, system clock), and `rst_i` (in, 1, reset); reset is asynchronous and active-high.
REQ-003 SHALL have port `rx_listo_i` (in, 1), a one-cycle strobe from the PS/2 receiver meaning a frame is complete.
REQ-004 SHALL have port `frame_i` (in, 9): [8:1] is the scan byte, LSB first as received; [0] is the received odd-parity bit.
REQ-005 SHALL have port `key_o` (out, 8), the make/break scan code at the FIFO head.
REQ-006 SHALL have port `ext_o` (out, 1), meaning the head event was E0-prefixed.
REQ-007 SHALL have port `brk_o` (out, 1), meaning the head event is a release (F0-prefixed).
REQ-008 SHALL have port `valid_o` (out, 1), meaning the FIFO head is valid.
REQ-009 SHALL have port `ready_i` (in, 1), the consumer accept signal; a pop occurs when valid_o and ready_i are both high.
REQ-010 SHALL have port `perr_o` (out, 1), a one-cycle pulse on a parity error.
REQ-011 SHALL have port `ovf_o` (out, 1), a sticky flag meaning an event was dropped because the FIFO was full.

Function
REQ-012 SHALL act only on clock edges where rx_listo_i=1, and SHALL ignore frame_i at all other times.
REQ-013 SHALL check parity: the XOR of frame_i[8:0] must be 1; on a mismatch it SHALL pulse perr_o the next cycle, discard the byte, and return the FSM to IDLE.
REQ-014 SHALL use FSM states IDLE, EXT, BRK, EXT_BRK; the reset state is IDLE.
REQ-015 SHALL transition IDLE --E0--> EXT and IDLE --F0--> BRK; any other byte emits {code, ext=0, brk=0} and stays in IDLE.
REQ-016 SHALL transition EXT --F0--> EXT_BRK; any other byte in EXT emits {code, 1, 0} and goes to IDLE.
REQ-017 SHALL, in BRK, emit {code, 0, 1} and go to IDLE; in EXT_BRK, emit {code, 1, 1} and go to IDLE.
REQ-018 SHALL treat E0 received in EXT or BRK, or F0 received in BRK or EXT_BRK, as a protocol violation: go to IDLE and emit nothing.
REQ-019 SHALL discard bytes 0xAA, 0xFA, 0xEE, 0xFE and 0x00 in any state, and return to IDLE.
REQ-020 SHALL write an emitted event into the FIFO on the same edge it samples the strobe; valid_o SHALL be high from the following cycle (1-cycle latency, no bypass).
REQ-021 SHALL drive key_o, ext_o and brk_o from the FIFO head register, holding them stable while valid_o=1 and ready_i=0.
REQ-022 SHALL, when the FIFO is full: pop and push on the same edge if both occur (no overflow); otherwise drop the push and set ovf_o.
REQ-023 SHALL, when the FIFO is empty, keep valid_o=0; ready_i SHALL have no effect.
REQ-024 SHALL wrap read and write pointers modulo FIFO_DEPTH, and keep the occupancy count in $clog2(FIFO_DEPTH)+1 bits.

Reset
REQ-025 SHALL, while rst_i=1, clear FSM=IDLE, pointers=0, count=0, key_o=0, ext_o=0, brk_o=0, valid_o=0, perr_o=0, ovf_o=0, and held-key=none.
REQ-026 SHALL, on reset mid-sequence (e.g. after E0), discard the partial sequence; the first byte after release is decoded from IDLE.
REQ-027 SHALL clear ovf_o only by reset.

Configuration
REQ-028 SHALL, with PS2_REPEAT_FILTER_EN defined, hold a held-key register {code, ext}: a make that matches it is suppressed (typematic repeat), a non-matching make is emitted and loaded into it, and a matching break is emitted and clears it.
REQ-029 SHALL, without PS2_REPEAT_FILTER_EN, emit every make, including repeats, and omit the held-key register.

Structure
REQ-030 SHALL define the constants SC_EXT=0xE0, SC_BRK=0xF0, SC_BAT=0xAA, SC_ACK=0xFA, SC_ECHO=0xEE, SC_RESEND=0xFE, the FSM state enum, and the event struct {key, ext, brk} in shared package ps2_pkg.
REQ-031 SHALL implement the FIFO as sub-module ps2_event_fifo (parameter DEPTH, width 10, same clock and reset).

Verification
REQ-032 SHALL cover: frame 0x1C with good parity -> key_o=0x1C, ext=0, brk=0, valid_o high 1 cycle after the strobe.
REQ-033 SHALL cover: frames E0, F0, 0x75 -> one event {0x75, ext=1, brk=1}; no event for the prefixes.
REQ-034 SHALL cover: frame 0x1C with bad parity after an F0 -> perr_o pulses 1 cycle, FSM returns to IDLE; a following 0x1B is emitted as a make.
REQ-035 SHALL cover: ready_i=0 with FIFO_DEPTH=4 and 5 makes -> the first 4 events are retained in order, ovf_o=1; then a pop and push on the same edge while full leaves ovf_o unchanged and count=4.
REQ-036 SHALL cover: with PS2_REPEAT_FILTER_EN, frames 0x1C, 0x1C, 0x1C, F0, 0x1C -> exactly two events, make 0x1C then break 0x1C.
REQ-037 SHALL cover: rst_i asserted asynchronously between E0 and 0x75 -> all outputs 0 immediately; after release, 0x75 is emitted with ext=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 scan-code decoder.
//
// Contents:
//   SC_* constants  : scan-code prefix bytes and keyboard status bytes
//   ps2_state_e     : decoder FSM states (IDLE, EXT, BRK, EXT_BRK)
//   ps2_event_t     : decoded key event {key, ext, brk}, 10 bits packed
//   is_status_byte  : true for bytes that never form part of a key event
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_NULL   = 8'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic [7:0] key;
    logic       ext;
    logic       brk;
  } ps2_event_t;

  // Keyboard status/handshake bytes: never part of a key event.
  function automatic logic is_status_byte(input logic [7:0] code);
    return (code == SC_BAT)  || (code == SC_ACK)    ||
           (code == SC_ECHO) || (code == SC_RESEND) ||
           (code == SC_NULL);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo -- small synchronous FIFO holding decoded key events.
//
// Parameters:
//   DEPTH  : number of entries, power of two, 2..16
//   WIDTH  : entry width in bits
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i/din_i : write request and data
//   pop_i        : read request (ignored while empty)
//   dout_o       : head entry, straight from the storage registers
//   valid_o      : FIFO not empty
//   drop_o       : push rejected this cycle because the FIFO was full
//                  and no pop freed a slot on the same edge
module ps2_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             drop_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] mem_reg [DEPTH];

  logic full;
  logic pop_ok;
  logic push_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign pop_ok  = pop_i && (count_reg != '0);
  // A full FIFO still accepts a push when a pop frees the head slot on
  // the same edge.
  assign push_ok = push_i && (!full || pop_ok);
  assign drop_o  = push_i && !push_ok;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (push_ok) begin
      mem_reg[wr_ptr_reg] <= din_i;
    end
  end

  assign dout_o  = mem_reg[rd_ptr_reg];
  assign valid_o = (count_reg != '0);

endmodule

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder -- turns PS/2 scan bytes into make/break key events.
//
// Parameters:
//   FIFO_DEPTH : event FIFO depth, power of two, 2..16
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   rx_listo_i    : one-cycle strobe, frame_i holds a complete frame
//   frame_i[8:1]  : scan byte; frame_i[0] : received odd-parity bit
//   key_o/ext_o/brk_o : head event (code, E0-prefixed, release)
//   valid_o/ready_i   : head valid / consumer accept (pop when both high)
//   perr_o        : one-cycle pulse after a frame with bad parity
//   ovf_o         : sticky, an event was dropped on a full FIFO
// Build option:
//   PS2_REPEAT_FILTER_EN : suppress typematic repeats of the held key
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_listo_i,
  input  logic [8:0] frame_i,
  output logic [7:0] key_o,
  output logic       ext_o,
  output logic       brk_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       perr_o,
  output logic       ovf_o
);

  ps2_state_e state_reg;
  ps2_state_e state_next;

  logic [7:0] code;
  logic       parity_ok;
  logic       dec_emit;
  ps2_event_t dec_ev;
  logic       push;
  logic       perr_reg;
  logic       ovf_reg;
  logic       fifo_drop;
  ps2_event_t head_ev;

  assign code      = frame_i[8:1];
  // Odd parity: the data bits plus the parity bit carry an odd number of 1s.
  assign parity_ok = ^frame_i;

  always_comb begin
    state_next = state_reg;
    dec_emit   = 1'b0;
    dec_ev     = '{key: code, ext: 1'b0, brk: 1'b0};
    if (rx_listo_i) begin
      if (!parity_ok || is_status_byte(code)) begin
        state_next = IDLE;
      end else begin
        unique case (state_reg)
          IDLE: begin
            if (code == SC_EXT)      state_next = EXT;
            else if (code == SC_BRK) state_next = BRK;
            else                     dec_emit   = 1'b1;
          end
          EXT: begin
            if (code == SC_BRK) begin
              state_next = EXT_BRK;
            end else begin
              // A second E0 is a protocol violation: drop it silently.
              state_next = IDLE;
              dec_emit   = (code != SC_EXT);
              dec_ev.ext = 1'b1;
            end
          end
          BRK: begin
            state_next = IDLE;
            dec_emit   = (code != SC_EXT) && (code != SC_BRK);
            dec_ev.brk = 1'b1;
          end
          EXT_BRK: begin
            state_next = IDLE;
            dec_emit   = (code != SC_BRK);
            dec_ev.ext = 1'b1;
            dec_ev.brk = 1'b1;
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      perr_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      perr_reg  <= rx_listo_i && !parity_ok;
      if (fifo_drop) ovf_reg <= 1'b1;
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  // Held key {code, ext}: repeats of it are typematic and get suppressed
  // until the matching break arrives.
  logic [8:0] held_reg;
  logic [8:0] held_next;
  logic       held_valid_reg;
  logic       held_valid_next;
  logic       held_match;

  assign held_match = held_valid_reg && (held_reg == {dec_ev.key, dec_ev.ext});

  always_comb begin
    push            = dec_emit;
    held_next       = held_reg;
    held_valid_next = held_valid_reg;
    if (dec_emit) begin
      if (!dec_ev.brk) begin
        if (held_match) begin
          push = 1'b0;
        end else begin
          held_next       = {dec_ev.key, dec_ev.ext};
          held_valid_next = 1'b1;
        end
      end else if (held_match) begin
        held_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      held_reg       <= '0;
      held_valid_reg <= 1'b0;
    end else begin
      held_reg       <= held_next;
      held_valid_reg <= held_valid_next;
    end
  end
`else
  assign push = dec_emit;
`endif

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ps2_event_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .din_i   (dec_ev),
    .pop_i   (ready_i),
    .dout_o  (head_ev),
    .valid_o (valid_o),
    .drop_o  (fifo_drop)
  );

  assign key_o  = head_ev.key;
  assign ext_o  = head_ev.ext;
  assign brk_o  = head_ev.brk;
  assign perr_o = perr_reg;
  assign ovf_o  = ovf_reg;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder -- self-checking bench for ps2_scan_decoder.
// Expected events are queued when frames are driven; a monitor pops and
// compares them whenever the DUT hands an event to the consumer.
// Define PS2_REPEAT_FILTER_EN for both bench and RTL to test the filter.
module tb_ps2_scan_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       strobe = 1'b0;
  logic [8:0] frame = 9'h0;
  logic       ready = 1'b1;
  logic [7:0] key;
  logic       ext;
  logic       brk;
  logic       valid;
  logic       perr;
  logic       ovf;

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_scan_decoder #(.FIFO_DEPTH(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_listo_i (strobe),
    .frame_i    (frame),
    .key_o      (key),
    .ext_o      (ext),
    .brk_o      (brk),
    .valid_o    (valid),
    .ready_i    (ready),
    .perr_o     (perr),
    .ovf_o      (ovf)
  );

  // Scoreboard monitor: sampled on the falling edge, away from the
  // rising edge where the pop takes effect.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: got key=%02h ext=%b brk=%b, required no event", key, ext, brk);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({key, ext, brk} !== e) begin
          failures++;
          $display("FAIL event: got key=%02h ext=%b brk=%b, required key=%02h ext=%b brk=%b",
                   key, ext, brk, e[9:2], e[1], e[0]);
        end else begin
          $display("event key=%02h ext=%b brk=%b ok", key, ext, brk);
        end
      end
    end
  end

  // One frame, strobe held for exactly one rising edge. Called at
  // posedge+1 and returns at posedge+1 so calls can be chained.
  task automatic send_frame(input logic [7:0] c, input bit good);
    frame  = {c, good ? ~(^c) : (^c)};
    strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0;
    frame  = 9'($urandom);
  endtask

  task automatic expect_ev(input logic [7:0] c, input logic e, input logic b);
    exp_q.push_back({c, e, b});
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (key !== 8'h00)  begin failures++; $display("FAIL reset_key: got %02h, required 00", key); end
    checks++; if (ext !== 1'b0)   begin failures++; $display("FAIL reset_ext: got %b, required 0", ext); end
    checks++; if (brk !== 1'b0)   begin failures++; $display("FAIL reset_brk: got %b, required 0", brk); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b, required 0", valid); end
    checks++; if (perr !== 1'b0)  begin failures++; $display("FAIL reset_perr: got %b, required 0", perr); end
    checks++; if (ovf !== 1'b0)   begin failures++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset done");
  endtask

  task automatic test_make;
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL make_pre_valid: got %b, required 0", valid); end
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1);
    checks++;
    if (valid !== 1'b1 || key !== 8'h1C) begin
      failures++;
      $display("FAIL make_latency: got valid=%b key=%02h, required valid=1 key=1c", valid, key);
    end
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL drain_make: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_ext_brk;
    expect_ev(8'h75, 1'b1, 1'b1);
    send_frame(8'hE0, 1'b1);
    send_frame(8'hF0, 1'b1);
    send_frame(8'h75, 1'b1);
    expect_ev(8'h1C, 1'b1, 1'b0);
    send_frame(8'hE0, 1'b1);
    send_frame(8'h1C, 1'b1);
    expect_ev(8'h1C, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b1);
    send_frame(8'h1C, 1'b1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL drain_ext_brk: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_parity;
    send_frame(8'hF0, 1'b1);
    send_frame(8'h1C, 1'b0);
    checks++;
    if (perr !== 1'b1) begin failures++; $display("FAIL perr_pulse: got %b, required 1", perr); end
    @(posedge clk); #1;
    checks++;
    if (perr !== 1'b0) begin failures++; $display("FAIL perr_width: got %b, required 0", perr); end
    expect_ev(8'h1B, 1'b0, 1'b0);
    send_frame(8'h1B, 1'b1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL drain_parity: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_discard;
    // Status byte after E0 cancels the prefix.
    send_frame(8'hE0, 1'b1);
    send_frame(8'hAA, 1'b1);
    expect_ev(8'h22, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1);
    // Protocol violations: E0 E0 and F0 F0.
    send_frame(8'hE0, 1'b1);
    send_frame(8'hE0, 1'b1);
    expect_ev(8'h23, 1'b0, 1'b0);
    send_frame(8'h23, 1'b1);
    send_frame(8'hF0, 1'b1);
    send_frame(8'hF0, 1'b1);
    expect_ev(8'h24, 1'b0, 1'b0);
    send_frame(8'h24, 1'b1);
    send_frame(8'hFA, 1'b1);
    send_frame(8'h00, 1'b1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL drain_discard: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_overflow;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_ev(8'(8'h10 + i), 1'b0, 1'b0);
      send_frame(8'(8'h10 + i), 1'b1);
    end
    checks++;
    if (ovf !== 1'b0 || key !== 8'h10 || dut.u_fifo.count_reg !== 3'd4) begin
      failures++;
      $display("FAIL ovf_fill: got ovf=%b key=%02h count=%0d, required ovf=0 key=10 count=4", ovf, key, dut.u_fifo.count_reg);
    end
    // Pop and push on the same edge while full.
    ready = 1'b1;
    expect_ev(8'h14, 1'b0, 1'b0);
    send_frame(8'h14, 1'b1);
    ready = 1'b0;
    checks++;
    if (ovf !== 1'b0 || key !== 8'h11 || dut.u_fifo.count_reg !== 3'd4) begin
      failures++;
      $display("FAIL ovf_poppush: got ovf=%b key=%02h count=%0d, required ovf=0 key=11 count=4", ovf, key, dut.u_fifo.count_reg);
    end
    // Push to a full FIFO without a pop is dropped.
    send_frame(8'h15, 1'b1);
    checks++;
    if (ovf !== 1'b1 || key !== 8'h11 || dut.u_fifo.count_reg !== 3'd4) begin
      failures++;
      $display("FAIL ovf_drop: got ovf=%b key=%02h count=%0d, required ovf=1 key=11 count=4", ovf, key, dut.u_fifo.count_reg);
    end
    ready = 1'b1;
    expect_ev(8'h16, 1'b0, 1'b0);
    send_frame(8'h16, 1'b1);
    ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (ovf !== 1'b1 || valid !== 1'b1 || key !== 8'h12 || dut.u_fifo.count_reg !== 3'd4) begin
      failures++;
      $display("FAIL ovf_hold: got ovf=%b valid=%b key=%02h count=%0d, required ovf=1 valid=1 key=12 count=4",
               ovf, valid, key, dut.u_fifo.count_reg);
    end
    ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL drain_ovf: got %0d pending, required 0", exp_q.size()); end
    checks++;
    if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b, required 1", ovf); end
  endtask

  task automatic test_reset_mid;
    ready = 1'b0;
    send_frame(8'h30, 1'b1);
    checks++;
    if (valid !== 1'b1) begin failures++; $display("FAIL rst_mid_pre_valid: got %b, required 1", valid); end
    send_frame(8'hE0, 1'b1);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({key, ext, brk, valid, perr, ovf} !== 13'h0) begin
      failures++;
      $display("FAIL rst_async: got key=%02h ext=%b brk=%b valid=%b perr=%b ovf=%b, required all 0",
               key, ext, brk, valid, perr, ovf);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    ready = 1'b1;
    expect_ev(8'h75, 1'b0, 1'b0);
    send_frame(8'h75, 1'b1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL drain_rst_mid: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_repeat;
`ifdef PS2_REPEAT_FILTER_EN
    expect_ev(8'h1C, 1'b0, 1'b0);
    expect_ev(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b1);
    send_frame(8'h1C, 1'b1);
    send_frame(8'h1C, 1'b1);
`else
    expect_ev(8'h1C, 1'b0, 1'b0);
    expect_ev(8'h1C, 1'b0, 1'b0);
    expect_ev(8'h1C, 1'b0, 1'b0);
    expect_ev(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b1);
    send_frame(8'h1C, 1'b1);
    send_frame(8'h1C, 1'b1);
`endif
    send_frame(8'hF0, 1'b1);
    send_frame(8'h1C, 1'b1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
    repeat (5) begin @(posedge clk); #1; end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL drain_repeat: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset;
    test_make;
    test_ext_brk;
    test_parity;
    test_discard;
    test_overflow;
    test_reset_mid;
    test_repeat;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
